// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, pixel type and page constants
package fb_pkg;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_WORDS = FB_W * FB_H;
   localparam int FB_AW    = 17;

   typedef logic [7:0] pixel_t;

   localparam logic PAGE_A = 1'b0;
   localparam logic PAGE_B = 1'b1;

   typedef enum logic {FLIP_IDLE, FLIP_ARMED} flip_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin one-hot grant, search starts at ptr_i
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);
   logic [PW-1:0] idx;

   always_comb begin
      grant_o = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (grant_o == '0 && req_i[idx]) grant_o[idx] = 1'b1;
      end
   end
endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - two-page framebuffer RAM arbiter: scanout priority, round-robin
// writers, page flip at the vsync falling edge
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int N_WR     = 2,
   parameter int FB_WORDS = fb_pkg::FB_WORDS,
   parameter int AW       = FB_AW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vsync,
   input  logic              scan_req,
   input  logic [AW-1:0]     scan_addr,
   output logic [7:0]        scan_data,
   output logic              scan_valid,
   input  logic [N_WR-1:0]   wr_valid,
   input  logic [N_WR*AW-1:0] wr_addr,
   input  logic [N_WR*8-1:0] wr_data,
   output logic [N_WR-1:0]   wr_ready,
   input  logic              flip_req,
   output logic              flip_pending,
   output logic              front_page,
   output logic              frame_start,
   output logic [AW:0]       mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);
   localparam int          PW       = (N_WR > 1) ? $clog2(N_WR) : 1;
   localparam logic [AW:0] FB_LIMIT = (AW+1)'(FB_WORDS);

   flip_state_e   state_q, state_d;
   logic          front_page_q, front_page_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          vsync_q;
   logic          scan_valid_q;

   logic [N_WR-1:0] grant;
   logic [AW-1:0]   sel_addr;
   pixel_t          sel_data;
   logic [PW-1:0]   sel_idx;
   logic            accept;
   logic            vs_edge;
   logic            back_page;

   assign vs_edge   = vsync_q & ~vsync;
   assign back_page = front_page_q ? PAGE_A : PAGE_B;
   assign accept    = ~scan_req & (|grant);

   rr_arbiter #(.N(N_WR), .PW(PW)) u_rr (
      .req_i   (wr_valid & {N_WR{~scan_req}}),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_idx  = '0;
      for (int i = 0; i < N_WR; i++) begin
         if (grant[i]) begin
            sel_addr = wr_addr[i*AW +: AW];
            sel_data = wr_data[i*8 +: 8];
            sel_idx  = PW'(i);
         end
      end
   end

   // Out-of-range writes are still acknowledged, only the RAM strobe is withheld
   always_comb begin
      wr_ready  = '0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (!reset) begin
         if (scan_req) begin
            mem_addr = {front_page_q, scan_addr};
         end else if (|grant) begin
            wr_ready  = grant;
            mem_addr  = {back_page, sel_addr};
            mem_wdata = sel_data;
            mem_we    = ({1'b0, sel_addr} < FB_LIMIT);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = (int'(sel_idx) == N_WR - 1) ? '0 : PW'(int'(sel_idx) + 1);
   end

   always_comb begin
      state_d      = state_q;
      front_page_d = front_page_q;
      case (state_q)
         FLIP_IDLE:  if (flip_req) state_d = FLIP_ARMED;
         FLIP_ARMED: if (vs_edge) begin
            state_d      = FLIP_IDLE;
            front_page_d = ~front_page_q;
         end
         default:    state_d = FLIP_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= FLIP_IDLE;
         front_page_q <= PAGE_A;
         rr_ptr_q     <= '0;
         vsync_q      <= 1'b1;
         scan_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         front_page_q <= front_page_d;
         rr_ptr_q     <= rr_ptr_d;
         vsync_q      <= vsync;
         scan_valid_q <= scan_req;
      end
   end

   assign flip_pending = (state_q == FLIP_ARMED);
   assign front_page   = front_page_q;
   assign frame_start  = vs_edge & ~reset;
   assign scan_valid   = scan_valid_q;
   assign scan_data    = reset ? 8'h00 : mem_rdata;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter with RAM model and scoreboards
module tb_fb_arbiter;
   localparam int N_WR = 2;
   localparam int AW   = 17;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              vsync = 1'b1;
   logic              scan_req = 1'b0;
   logic [AW-1:0]     scan_addr = '0;
   logic [7:0]        scan_data;
   logic              scan_valid;
   logic [N_WR-1:0]   wr_valid = '0;
   logic [N_WR*AW-1:0] wr_addr = '0;
   logic [N_WR*8-1:0] wr_data = '0;
   logic [N_WR-1:0]   wr_ready;
   logic              flip_req = 1'b0;
   logic              flip_pending;
   logic              front_page;
   logic              frame_start;
   logic [AW:0]       mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   typedef struct {
      int          idx;
      logic [AW:0] addr;
      logic [7:0]  data;
      logic        we;
   } wr_exp_t;

   logic [7:0] scan_q[$];
   wr_exp_t    wr_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   bit [7:0] ram     [0:(1<<(AW+1))-1];
   bit       written [0:(1<<(AW+1))-1];

   fb_arbiter #(.N_WR(N_WR), .FB_WORDS(76800), .AW(AW)) dut (
      .clock(clock), .reset(reset), .vsync(vsync),
      .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .flip_req(flip_req), .flip_pending(flip_pending), .front_page(front_page),
      .frame_start(frame_start), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #20 clock = ~clock;

   function automatic logic [7:0] bg(input logic [AW:0] a);
      return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] peek(input logic [AW:0] a);
      return written[a] ? ram[a] : bg(a);
   endfunction

   // Synchronous RAM, one-cycle read latency; unwritten cells read a fixed pattern
   always @(posedge clock) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : bg(mem_addr);
   end

   always @(negedge clock) begin
      if (scan_valid === 1'b1) begin
         n_checks++;
         if (scan_q.size() == 0) $display("FAIL scan_unexpected: got scan_valid=1 expected none");
         else begin
            logic [7:0] e;
            e = scan_q.pop_front();
            if (scan_data !== e) $display("FAIL scan_data: got %h expected %h", scan_data, e);
            else n_pass++;
         end
      end
      if (wr_ready !== '0) begin
         n_checks++;
         if (wr_q.size() == 0) $display("FAIL grant_unexpected: got wr_ready=%b expected 00", wr_ready);
         else begin
            wr_exp_t e;
            logic [N_WR-1:0] g;
            e = wr_q.pop_front();
            g = N_WR'(1 << e.idx);
            if (wr_ready !== g || mem_addr !== e.addr || mem_we !== e.we || mem_wdata !== e.data)
               $display("FAIL grant: got ready=%b addr=%h we=%b data=%h expected ready=%b addr=%h we=%b data=%h",
                        wr_ready, mem_addr, mem_we, mem_wdata, g, e.addr, e.we, e.data);
            else n_pass++;
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_w(input int i, input int a, input logic [7:0] d);
      wr_addr[i*AW +: AW] = AW'(a);
      wr_data[i*8 +: 8]   = d;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      wr_valid = 2'b11;
      repeat (3) cyc();
      #1;
      n_checks++; if (wr_ready !== 2'b00 || mem_we !== 1'b0 || mem_addr !== '0)
         $display("FAIL reset_comb: got ready=%b we=%b addr=%h expected 00/0/0", wr_ready, mem_we, mem_addr);
      else n_pass++;
      n_checks++; if ({flip_pending, front_page, scan_valid, frame_start} !== 4'b0000)
         $display("FAIL reset_regs: got %b expected 0000", {flip_pending, front_page, scan_valid, frame_start});
      else n_pass++;
      reset    = 1'b0;
      wr_valid = 2'b00;
      cyc();
   endtask

   task automatic test_scan_priority();
      wr_valid = 2'b11;
      set_w(0, 7, 8'h11);
      set_w(1, 8, 8'h22);
      for (int k = 0; k < 10; k++) begin
         scan_req  = 1'b1;
         scan_addr = AW'(100 + k);
         scan_q.push_back(bg({1'b0, scan_addr}));
         #1;
         n_checks++; if (wr_ready !== 2'b00 || mem_we !== 1'b0 || mem_addr !== {1'b0, scan_addr})
            $display("FAIL scan_prio: got ready=%b we=%b addr=%h expected 00/0/%h", wr_ready, mem_we, mem_addr, {1'b0, scan_addr});
         else n_pass++;
         cyc();
         n_checks++; if (scan_valid !== 1'b1) $display("FAIL scan_valid_hi: got %b expected 1", scan_valid);
         else n_pass++;
      end
      scan_req = 1'b0;
      wr_valid = 2'b00;
      cyc();
      n_checks++; if (scan_valid !== 1'b0 || scan_q.size() != 0)
         $display("FAIL scan_drain: got valid=%b left=%0d expected 0/0", scan_valid, scan_q.size());
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int n[2];
      n[0] = 0;
      n[1] = 0;
      wr_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         int g;
         g = k % 2;
         set_w(0, 10 + n[0], 8'hA0 + 8'(n[0]));
         set_w(1, 20 + n[1], 8'hB0 + 8'(n[1]));
         wr_q.push_back('{g, {1'b1, AW'((g == 0 ? 10 : 20) + n[g])}, (g == 0 ? 8'hA0 : 8'hB0) + 8'(n[g]), 1'b1});
         #1;
         n_checks++; if (wr_ready !== N_WR'(1 << g)) $display("FAIL rr_order: got %b expected %b", wr_ready, N_WR'(1 << g));
         else n_pass++;
         cyc();
         n[g]++;
      end
      wr_valid = 2'b00;
      for (int j = 0; j < 3; j++) begin
         n_checks++; if (peek({1'b1, AW'(10 + j)}) !== 8'hA0 + 8'(j) || peek({1'b1, AW'(20 + j)}) !== 8'hB0 + 8'(j))
            $display("FAIL rr_ram: got %h/%h expected %h/%h", peek({1'b1, AW'(10 + j)}), peek({1'b1, AW'(20 + j)}),
                     8'hA0 + 8'(j), 8'hB0 + 8'(j));
         else n_pass++;
      end
   endtask

   task automatic test_out_of_range();
      logic [AW:0] a;
      a        = {1'b1, AW'(76800)};
      wr_valid = 2'b10;
      set_w(1, 76800, 8'hE0);
      wr_q.push_back('{1, a, 8'hE0, 1'b0});
      #1;
      n_checks++; if (wr_ready !== 2'b10 || mem_we !== 1'b0)
         $display("FAIL oor_ack: got ready=%b we=%b expected 10/0", wr_ready, mem_we);
      else n_pass++;
      cyc();
      wr_valid = 2'b00;
      n_checks++; if (peek(a) !== bg(a)) $display("FAIL oor_ram: got %h expected %h", peek(a), bg(a));
      else n_pass++;
   endtask

   task automatic test_flip();
      flip_req = 1'b1;
      cyc();
      flip_req = 1'b0;
      n_checks++; if (flip_pending !== 1'b1 || front_page !== 1'b0)
         $display("FAIL flip_arm: got pend=%b front=%b expected 1/0", flip_pending, front_page);
      else n_pass++;
      repeat (3) cyc();
      vsync = 1'b0;
      #1;
      n_checks++; if (frame_start !== 1'b1 || front_page !== 1'b0)
         $display("FAIL flip_edge: got fs=%b front=%b expected 1/0", frame_start, front_page);
      else n_pass++;
      cyc();
      n_checks++; if (front_page !== 1'b1 || flip_pending !== 1'b0 || frame_start !== 1'b0)
         $display("FAIL flip_done: got front=%b pend=%b fs=%b expected 1/0/0", front_page, flip_pending, frame_start);
      else n_pass++;
      repeat (2) cyc();
      vsync = 1'b1;
      cyc();
      wr_valid = 2'b01;
      set_w(0, 5, 8'h3C);
      wr_q.push_back('{0, {1'b0, AW'(5)}, 8'h3C, 1'b1});
      cyc();
      wr_valid = 2'b00;
      n_checks++; if (peek({1'b0, AW'(5)}) !== 8'h3C) $display("FAIL flip_write: got %h expected 3c", peek({1'b0, AW'(5)}));
      else n_pass++;
      scan_req  = 1'b1;
      scan_addr = AW'(10);
      scan_q.push_back(8'hA0);
      cyc();
      scan_req = 1'b0;
      cyc();
      n_checks++; if (scan_q.size() != 0) $display("FAIL flip_scan: got %0d pending expected 0", scan_q.size());
      else n_pass++;
   endtask

   task automatic test_coincident();
      vsync    = 1'b0;
      flip_req = 1'b1;
      #1;
      n_checks++; if (frame_start !== 1'b1) $display("FAIL coinc_fs: got %b expected 1", frame_start);
      else n_pass++;
      cyc();
      flip_req = 1'b0;
      n_checks++; if (front_page !== 1'b1 || flip_pending !== 1'b1)
         $display("FAIL coinc_idle: got front=%b pend=%b expected 1/1", front_page, flip_pending);
      else n_pass++;
      vsync = 1'b1;
      repeat (3) cyc();
      vsync = 1'b0;
      cyc();
      n_checks++; if (front_page !== 1'b0 || flip_pending !== 1'b0)
         $display("FAIL coinc_next: got front=%b pend=%b expected 0/0", front_page, flip_pending);
      else n_pass++;
      vsync = 1'b1;
      cyc();
      flip_req = 1'b1;
      cyc();
      cyc();
      flip_req = 1'b0;
      cyc();
      // Write accepted on the toggle cycle goes to the pre-toggle back page
      vsync    = 1'b0;
      flip_req = 1'b1;
      wr_valid = 2'b10;
      set_w(1, 33, 8'h77);
      wr_q.push_back('{1, {1'b1, AW'(33)}, 8'h77, 1'b1});
      cyc();
      flip_req = 1'b0;
      wr_valid = 2'b00;
      n_checks++; if (front_page !== 1'b1 || flip_pending !== 1'b0)
         $display("FAIL double_req: got front=%b pend=%b expected 1/0", front_page, flip_pending);
      else n_pass++;
      n_checks++; if (peek({1'b1, AW'(33)}) !== 8'h77) $display("FAIL toggle_write: got %h expected 77", peek({1'b1, AW'(33)}));
      else n_pass++;
      vsync = 1'b1;
      cyc();
      vsync = 1'b0;
      cyc();
      n_checks++; if (front_page !== 1'b1) $display("FAIL no_reflip: got %b expected 1", front_page);
      else n_pass++;
      vsync = 1'b1;
      cyc();
   endtask

   task automatic test_reset_mid();
      wr_valid = 2'b01;
      set_w(0, 40, 8'h44);
      wr_q.push_back('{0, {1'b0, AW'(40)}, 8'h44, 1'b1});
      cyc();
      wr_valid = 2'b00;
      flip_req = 1'b1;
      cyc();
      flip_req = 1'b0;
      n_checks++; if (flip_pending !== 1'b1) $display("FAIL mid_arm: got %b expected 1", flip_pending);
      else n_pass++;
      reset    = 1'b1;
      wr_valid = 2'b11;
      #1;
      n_checks++; if (wr_ready !== 2'b00 || mem_we !== 1'b0)
         $display("FAIL mid_gate: got ready=%b we=%b expected 00/0", wr_ready, mem_we);
      else n_pass++;
      cyc();
      reset = 1'b0;
      n_checks++; if (flip_pending !== 1'b0 || front_page !== 1'b0)
         $display("FAIL mid_regs: got pend=%b front=%b expected 0/0", flip_pending, front_page);
      else n_pass++;
      set_w(0, 50, 8'h55);
      set_w(1, 60, 8'h66);
      wr_q.push_back('{0, {1'b1, AW'(50)}, 8'h55, 1'b1});
      #1;
      n_checks++; if (wr_ready !== 2'b01) $display("FAIL mid_grant: got %b expected 01", wr_ready);
      else n_pass++;
      cyc();
      wr_valid = 2'b00;
      vsync    = 1'b0;
      cyc();
      n_checks++; if (front_page !== 1'b0 || flip_pending !== 1'b0)
         $display("FAIL mid_noflip: got front=%b pend=%b expected 0/0", front_page, flip_pending);
      else n_pass++;
      vsync = 1'b1;
      cyc();
      n_checks++; if (wr_q.size() != 0 || scan_q.size() != 0)
         $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", wr_q.size(), scan_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_scan_priority();
      test_round_robin();
      test_out_of_range();
      test_flip();
      test_coincident();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Arbitrates a single-port, two-page 320x240 RRRGGGBB framebuffer RAM between the display scanout reader and N drawing-engine writers. Also owns page flipping: front page reads, back page writes, swap at the vsync pulse. Sits between the scanout fetch unit and drawing engines on one side and the framebuffer RAM on the other. Runs on the 25 MHz pixel clock next to `vga_driver`.

## Interface
- `N_WR`, 2: number of writer ports (1..4).
- `FB_WORDS`, 76800: pixels per page (320*240).
- `AW`, 17: pixel address width within a page.

- `clock`  in  1: pixel clock. One clock domain only.
- `reset`  in  1: synchronous, active-high.
- `vsync`  in  1: active-low vsync from `vga_driver`.
- `scan_req`  in  1: scanout read request this cycle.
- `scan_addr`  in  AW: pixel address of the scanout read.
- `scan_data`  out  8: read data.
- `scan_valid`  out  1: `scan_data` is valid.
- `wr_valid`  in  N_WR: per-writer request.
- `wr_addr`  in  N_WR*AW: packed addresses; writer i uses slice [i*AW +: AW].
- `wr_data`  in  N_WR*8: packed pixels.
- `wr_ready`  out  N_WR: one-hot grant. The write is accepted in the cycle where valid and ready are both high.
- `flip_req`  in  1: single-cycle page swap request.
- `flip_pending`  out  1: a swap is armed and waiting for vsync.
- `front_page`  out  1: page currently scanned out.
- `frame_start`  out  1: one-cycle pulse on the vsync falling edge.
- `mem_addr`  out  AW+1: {page, pixel address}.
- `mem_we`  out  1: RAM write enable.
- `mem_wdata`  out  8: RAM write data.
- `mem_rdata`  in  8: RAM read data. Synchronous RAM, 1-cycle read latency.

## Operation
- **Per-cycle arbitration (combinational grant).**
  - If `scan_req`=1: `mem_addr` = {front_page, scan_addr} and `mem_we` = 0. All `wr_ready` = 0. Scanout has absolute priority.
  - Otherwise: round-robin grant among asserted `wr_valid`. The search starts at `rr_ptr`, then rr_ptr+1, and so on, wrapping at N_WR.
    - `wr_ready` is high only for the grantee.
    - `mem_addr` = {~front_page, addr_i}, `mem_wdata` = data_i.
    - `mem_we` = 1 if addr_i < FB_WORDS. An out-of-range write is still acknowledged (`wr_ready`=1) and silently dropped.
  - On an accepted write from writer i, `rr_ptr` becomes (i+1) mod N_WR. With no accepted write, `rr_ptr` holds.
  - If no requester is active, `mem_we` = 0 and `mem_addr` = 0.
- **`wr_ready` dependence.** `wr_ready` may depend combinationally on `wr_valid`. Writers hold addr/data stable until accepted.
- **Scanout return.** `scan_valid` is `scan_req` delayed one cycle. `scan_data` = `mem_rdata` passthrough. Scanout addresses are not range-checked.
- **Page flip.**
  - `vsync_q` registers `vsync`. An edge is detected when `vsync_q`=1 and `vsync`=0; it pulses `frame_start`.
  - States are IDLE (`flip_pending`=0) and ARMED (`flip_pending`=1).
  - IDLE --flip_req--> ARMED.
  - ARMED --edge--> IDLE, and `front_page` toggles on the same edge.
  - `flip_req` while ARMED is ignored, including on the edge cycle. No double flip.
  - `flip_req` coinciding with an edge while IDLE arms the swap; it takes effect at the next frame's edge.
- **Writes during a flip.** A write accepted in the toggle cycle uses the pre-toggle `front_page`. It therefore lands in the page that becomes front.

## Timing
- **Reset values:** `front_page`=0, `flip_pending`=0, `rr_ptr`=0, `vsync_q`=1, `scan_valid`=0, `frame_start`=0. All combinational outputs are 0 while `reset`=1. Reset mid-frame discards a pending flip.
- **Scanout read latency:** exactly 1 cycle, request to `scan_valid`.
- **Write:** committed at the clock edge of acceptance. Zero-cycle grant, no buffering.
- **Flip:** `front_page` changes one clock after the falling vsync edge is seen, i.e. the first cycle with `vsync_q`=0. It lands during the vsync pulse, so never mid-active-frame.
- **`frame_start`:** asserted in the detection cycle (combinational from `vsync` and `vsync_q`).

## Structure
- Package `fb_pkg`:
  - `FB_W`=320, `FB_H`=240, `FB_WORDS`, `FB_AW`=17.
  - Pixel typedef (8-bit RRRGGGBB).
  - Page-bit constant names `PAGE_A`=0, `PAGE_B`=1.
- Sub-module `rr_arbiter`: N-way round-robin grant, inputs req/ptr, output one-hot grant. It also serves future shared resources.
- Flip FSM, vsync edge detect and mux live in `fb_arbiter`.

## Test plan
- **Scanout priority:** `scan_req`=1 with both writers valid for 10 cycles → `wr_ready`=00 throughout; `mem_addr`={0,scan_addr}; `scan_valid` high cycles 1..10.
- **Round-robin fairness:** both writers valid continuously, no scanout → grants alternate 01,10,01,10… starting with writer 0 after reset; RAM back page (page 1) holds the written data.
- **Out-of-range write:** writer 1 addr 76800, data 0xE0 → `wr_ready`[1]=1, `mem_we`=0, RAM unchanged.
- **Flip:** `flip_req` mid-frame → `flip_pending`=1; at the vsync falling edge `frame_start` pulses, `front_page` 0→1 next cycle, `flip_pending`=0. Subsequent writes target page 0.
- **Coincident events:** `flip_req` on the edge cycle while IDLE → no flip now, flip at the next edge. `flip_req` twice while ARMED → single toggle.
- **Reset mid-operation:** reset while ARMED with `rr_ptr`=1 → `flip_pending`=0, `front_page`=0, next grant to writer 0, no flip at the following vsync.
